// File: rtl/imm_extend_if.sv
// imm_extend_if: decode-to-execute immediate handshake bundle.
// Revision 1.0
`default_nettype none

interface imm_extend_if #(
  parameter int DATA_W = 64
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_inst;
  logic [2:0]        i_mode;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_ext;
  logic [2:0]        o_mode;
  logic              o_err;

  modport slave (
    input  i_flush, i_valid, i_inst, i_mode, i_ready,
    output o_ready, o_valid, o_ext, o_mode, o_err
  );

  modport master (
    output i_flush, i_valid, i_inst, i_mode, i_ready,
    input  o_ready, o_valid, o_ext, o_mode, o_err
  );
endinterface

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered ARMv8 immediate extractor with a 2-entry skid buffer.
// Revision 1.0
`default_nettype none

module imm_extend_pipe #(
  parameter int DATA_W   = 64,
  parameter bit ERR_ZERO = 1'b1
) (
  input  wire             i_clk,
  input  wire             i_rst_n,
  imm_extend_if.slave     bus
);
  localparam logic [2:0] c_MODE_I  = 3'd0;
  localparam logic [2:0] c_MODE_D  = 3'd1;
  localparam logic [2:0] c_MODE_B  = 3'd2;
  localparam logic [2:0] c_MODE_CB = 3'd3;
  localparam logic [2:0] c_MODE_IW = 3'd4;

  logic [DATA_W-1:0] w_ext;
  logic              w_err;
  logic [DATA_W-1:0] w_iw;
  logic              w_unused;

  logic              r_v0;
  logic [DATA_W-1:0] r_ext0;
  logic [2:0]        r_mode0;
  logic              r_err0;
  logic              r_v1;
  logic [DATA_W-1:0] r_ext1;
  logic [2:0]        r_mode1;
  logic              r_err1;

  logic w_accept;
  logic w_consume;

  assign w_unused = &{1'b0, bus.i_inst[31:26]};
  assign w_iw     = {{(DATA_W-16){1'b0}}, bus.i_inst[20:5]};

  always_comb begin
    w_ext = '0;
    w_err = 1'b0;
    case (bus.i_mode)
      c_MODE_I: begin
        if (bus.i_inst[22])
          w_ext = {{(DATA_W-24){1'b0}}, bus.i_inst[21:10], 12'h000};
        else
          w_ext = {{(DATA_W-12){1'b0}}, bus.i_inst[21:10]};
      end
      c_MODE_D:  w_ext = {{(DATA_W-9){bus.i_inst[20]}}, bus.i_inst[20:12]};
      c_MODE_B:  w_ext = {{(DATA_W-28){bus.i_inst[25]}}, bus.i_inst[25:0], 2'b00};
      c_MODE_CB: w_ext = {{(DATA_W-21){bus.i_inst[23]}}, bus.i_inst[23:5], 2'b00};
      c_MODE_IW: begin
        // A 32-bit result cannot hold halfword positions 2 and 3.
        if (DATA_W == 32 && bus.i_inst[22])
          w_err = 1'b1;
        else
          w_ext = w_iw << {bus.i_inst[22:21], 4'b0000};
      end
      default: begin
        w_err = 1'b1;
        w_ext = ERR_ZERO ? '0 : {{(DATA_W-26){1'b0}}, bus.i_inst[25:0]};
      end
    endcase
  end

  // Ready is the skid entry being empty, so it never sees i_ready combinationally.
  assign w_accept  = bus.i_valid && !r_v1;
  assign w_consume = r_v0 && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v0    <= 1'b0;
      r_ext0  <= '0;
      r_mode0 <= '0;
      r_err0  <= 1'b0;
      r_v1    <= 1'b0;
      r_ext1  <= '0;
      r_mode1 <= '0;
      r_err1  <= 1'b0;
    end else if (bus.i_flush) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (!r_v0 || w_consume) begin
      if (r_v1) begin
        r_v0    <= 1'b1;
        r_ext0  <= r_ext1;
        r_mode0 <= r_mode1;
        r_err0  <= r_err1;
        r_v1    <= 1'b0;
      end else if (w_accept) begin
        r_v0    <= 1'b1;
        r_ext0  <= w_ext;
        r_mode0 <= bus.i_mode;
        r_err0  <= w_err;
      end else begin
        r_v0 <= 1'b0;
      end
    end else if (w_accept) begin
      r_v1    <= 1'b1;
      r_ext1  <= w_ext;
      r_mode1 <= bus.i_mode;
      r_err1  <= w_err;
    end
  end

  assign bus.o_ready = !r_v1;
  assign bus.o_valid = r_v0;
  assign bus.o_ext   = r_ext0;
  assign bus.o_mode  = r_mode0;
  assign bus.o_err   = r_err0;
endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: 64-bit and 32-bit instances share clock and reset.
`default_nettype none

module tb_imm_extend_pipe;
  typedef struct packed {
    logic [63:0] ext;
    logic [2:0]  mode;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q64[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  imm_extend_if #(.DATA_W(64)) b64 ();
  imm_extend_if #(.DATA_W(32)) b32 ();

  imm_extend_pipe #(.DATA_W(64), .ERR_ZERO(1'b1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b64.slave));
  imm_extend_pipe #(.DATA_W(32), .ERR_ZERO(1'b1)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b32.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: pop and compare whenever an output is consumed.
  always @(negedge clk) begin
    if (rst_n && b64.o_valid && b64.i_ready) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected64 actual=%h required=none", b64.o_ext);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("ext64", b64.o_ext, e.ext);
        chk("mode64", {61'd0, b64.o_mode}, {61'd0, e.mode});
        chk("err64", {63'd0, b64.o_err}, {63'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b32.o_valid && b32.i_ready) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected32 actual=%h required=none", b32.o_ext);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("ext32", {32'd0, b32.o_ext}, {32'd0, e.ext[31:0]});
        chk("mode32", {61'd0, b32.o_mode}, {61'd0, e.mode});
        chk("err32", {63'd0, b32.o_err}, {63'd0, e.err});
      end
    end
  end

  // Drives one instruction and waits (bounded) for it to be accepted.
  task automatic send(input bit sel, input logic [31:0] inst, input logic [2:0] mode,
                      input logic [63:0] exp_ext, input logic exp_err, input bit push);
    bit ok = 1'b0;
    exp_t e;
    e.ext = exp_ext; e.mode = mode; e.err = exp_err;
    if (sel) begin b32.i_valid = 1'b1; b32.i_inst = inst; b32.i_mode = mode; end
    else     begin b64.i_valid = 1'b1; b64.i_inst = inst; b64.i_mode = mode; end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sel ? b32.o_ready : b64.o_ready) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) begin
          if (sel) q32.push_back(e); else q64.push_back(e);
        end
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    #1;
    if (sel) b32.i_valid = 1'b0; else b64.i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    b64.i_flush = 1'b0; b64.i_valid = 1'b0; b64.i_inst = '0; b64.i_mode = '0; b64.i_ready = 1'b1;
    b32.i_flush = 1'b0; b32.i_valid = 1'b0; b32.i_inst = '0; b32.i_mode = '0; b32.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, b64.o_valid}, 64'd0);
    chk("rst_ready", {63'd0, b64.o_ready}, 64'd1);
    chk("rst_ext", b64.o_ext, 64'd0);
    chk("rst_mode_err", {60'd0, b64.o_mode, b64.o_err}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Per-format values, back-to-back with i_ready=1.
    send(0, 32'h003F_FC00, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0, 1);
    @(negedge clk);
    chk("latency_valid", {63'd0, b64.o_valid}, 64'd1);
    @(posedge clk); #1;
    send(0, 32'h007F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 1'b0, 1);
    send(0, 32'h0010_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1);
    send(0, 32'h000F_F000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0, 1);
    send(0, 32'h0200_0000, 3'd2, 64'hFFFF_FFFF_F800_0000, 1'b0, 1);
    send(0, 32'h0000_0020, 3'd3, 64'h0000_0000_0000_0004, 1'b0, 1);
    send(0, 32'h0080_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 1);
    send(0, 32'h0077_DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0, 1);
    send(0, 32'h03FF_FFFF, 3'd6, 64'h0, 1'b1, 1);

    // 32-bit instance: wide-move halfword range.
    send(1, 32'h0057_DDE0, 3'd4, 64'h0, 1'b1, 1);
    send(1, 32'h0037_DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 1'b0, 1);
    send(1, 32'h0010_0000, 3'd1, 64'h0000_0000_FFFF_FF00, 1'b0, 1);
    repeat (3) @(posedge clk); #1;

    // Back-pressure: B and D fill both entries, I waits.
    b64.i_ready = 1'b0;
    send(0, 32'h0000_0001, 3'd2, 64'h4, 1'b0, 1);
    send(0, 32'h000F_F000, 3'd1, 64'hFF, 1'b0, 1);
    @(negedge clk);
    chk("bp_ready_low", {63'd0, b64.o_ready}, 64'd0);
    @(posedge clk); #1;
    fork
      send(0, 32'h0000_0400, 3'd0, 64'h1, 1'b0, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_ready", {63'd0, b64.o_ready}, 64'd0);
          chk("bp_hold_ext", b64.o_ext, 64'h4);
        end
        @(posedge clk); #1;
        b64.i_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Flush with both entries full and a third instruction presented.
    b64.i_ready = 1'b0;
    send(0, 32'h0000_0002, 3'd2, 64'h8, 1'b0, 0);
    send(0, 32'h0000_0003, 3'd2, 64'hC, 1'b0, 0);
    b64.i_valid = 1'b1; b64.i_inst = 32'h0000_0040; b64.i_mode = 3'd3; b64.i_flush = 1'b1;
    @(posedge clk); #1;
    b64.i_flush = 1'b0; b64.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {63'd0, b64.o_valid}, 64'd0);
    chk("flush_ready", {63'd0, b64.o_ready}, 64'd1);
    b64.i_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Asynchronous reset while an output is held.
    b64.i_ready = 1'b0;
    send(0, 32'h0000_0020, 3'd3, 64'h4, 1'b0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, b64.o_valid}, 64'd0);
    chk("arst_ext", b64.o_ext, 64'd0);
    chk("arst_ready", {63'd0, b64.o_ready}, 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    b64.i_ready = 1'b1;
    @(posedge clk); #1;
    send(0, 32'h0000_0020, 3'd3, 64'h4, 1'b0, 1);
    @(negedge clk);
    chk("post_rst_valid", {63'd0, b64.o_valid}, 64'd1);
    repeat (3) @(posedge clk); #1;

    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate extractor/extender for the ARMv8 decode stage.
- Takes a raw 32-bit instruction word plus a format select, and produces a DATA_W-bit immediate with per-format sign/zero extension, shift and wide-move placement.
- Sits between decode and the execute operand mux, with a valid/ready handshake and a 2-entry skid buffer so execute back-pressure never drops an immediate.

Parameters:
- DATA_W, 64, output immediate width; legal values 32 or 64.
- ERR_ZERO, 1, when 1 an illegal-format result is forced to 0; when 0 the raw unextended field is passed through.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous flush; empties both buffer entries.
- i_valid  input  1  upstream has an instruction.
- o_ready  output  1  block can accept; registered, equals "skid entry empty".
- i_inst  input  32  instruction word.
- i_mode  input  3  format: 0=I, 1=D, 2=B, 3=CB, 4=IW, 5-7 illegal.
- o_valid  output  1  o_ext/o_err/o_mode valid.
- i_ready  input  1  downstream accepts.
- o_ext  output  DATA_W  extended immediate.
- o_mode  output  3  format tag travelling with the immediate.
- o_err  output  1  illegal format or unrepresentable immediate.

Behaviour:
- Reset (i_rst_n=0, async): o_valid=0, o_ready=1, o_ext=0, o_mode=0, o_err=0, skid entry invalid.
- Extension rules (combinational, applied to i_inst before the register):
  - I: zero-extend i_inst[21:10]; if i_inst[22]=1, shift left by 12.
  - D: sign-extend i_inst[20:12] (9-bit signed).
  - B: sign-extend {i_inst[25:0],2'b00} (28-bit signed).
  - CB: sign-extend {i_inst[23:5],2'b00} (21-bit signed).
  - IW: zero-extend i_inst[20:5], shifted left by 16*i_inst[22:21].
  - If DATA_W=32 and mode IW with hw>=2: o_err=1, value=0.
  - Modes 5-7: o_err=1; value=0 if ERR_ZERO=1, else zero-extended i_inst[25:0].
- Handshake:
  - Input accepted when i_valid && o_ready.
  - Output consumed when o_valid && i_ready.
  - Latency: an accepted instruction appears on o_ext exactly 1 cycle later if the output register was empty or was being consumed that cycle.
- Buffering:
  - Output register (entry 0) plus skid register (entry 1).
  - If input is accepted while entry 0 is valid and not consumed, the result goes to entry 1 and o_ready drops next cycle.
  - When entry 0 is consumed and entry 1 is valid, entry 1 moves to entry 0 and o_ready rises next cycle.
  - Order is strictly FIFO.
  - Outputs hold stable while o_valid=1 && i_ready=0.
- Simultaneous accept + consume with entry 1 empty: entry 0 is replaced by the new result; o_valid stays 1.
- Flush: i_flush=1 clears both entries next edge (o_valid=0, o_ready=1) and has priority over a same-cycle accept; the flushed input is dropped.
- Reset asserted mid-transfer: state is lost immediately and outputs return to reset values without waiting for a clock edge.
- o_ready depends only on registered state; there is no combinational path from i_ready to o_ready.

Test Plan:
- Per-format values, DATA_W=64, i_ready held 1. Each input -> o_ext one cycle later:
  - I, i_inst[21:10]=0xFFF, [22]=0 -> 0x0000000000000FFF.
  - I, same field, [22]=1 -> 0x0000000000FFF000.
  - D, [20:12]=0x100 -> 0xFFFFFFFFFFFFFF00.
  - B, [25:0]=0x2000000 -> 0xFFFFFFFFF8000000.
  - CB, [23:5]=0x00001 -> 0x0000000000000004.
  - IW, [20:5]=0xBEEF, hw=3 -> 0xBEEF000000000000.
- Illegal format: mode=6, ERR_ZERO=1 -> o_ext=0, o_err=1, o_mode=6.
- DATA_W=32, IW with hw=2 -> o_err=1, o_ext=0. Same instruction with hw=1 -> 0xBEEF0000, o_err=0.
- Back-pressure: i_ready=0, stream three instructions (B, D, I).
  - First two are accepted; o_ready=0 from the cycle after the second accept; the third is held.
  - Release i_ready -> outputs appear in order B, D, I with no loss or duplication.
- Flush with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1; none of the three results ever appears on the output.
- Async reset: assert i_rst_n=0 between clock edges with o_valid=1 -> o_valid=0 and o_ext=0 before the next edge. Deassert -> first accepted instruction yields correct data after 1 cycle.
